uart_reg_ctrl: RTL and testbench
================================

UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 11520, UART line bit rate in bit/s.
REQ-003 Parameter TIMEOUT_CYCLES, default 86806 (20 bit periods at the defaults), maximum idle gap between the command byte and the data byte of one write.
REQ-004 clk  in  1  system clock; all logic is on the rising edge; one clock only.
REQ-005 resetn  in  1  reset; synchronous, active-low.
REQ-006 uart_rx_valid  in  1  one-cycle strobe; uart_rx_data holds a received byte.
REQ-007 uart_rx_data  in  8  received byte.
REQ-008 uart_tx_busy  in  1  UART transmitter is busy; it accepts no byte while high.
REQ-009 uart_tx_en  out  1  one-cycle strobe that launches uart_tx_data.
REQ-010 uart_tx_data  out  8  byte to transmit.
REQ-011 reg_we  out  1  one-cycle register write strobe.
REQ-012 reg_re  out  1  one-cycle register read strobe.
REQ-013 reg_addr  out  7  register address.
REQ-014 reg_wdata  out  8  register write data.
REQ-015 reg_rdata  in  8  register read data; valid on the cycle after reg_re.
REQ-016 cmd_drop  out  1  one-cycle pulse when a received byte is discarded.
REQ-017 cmd_timeout  out  1  one-cycle pulse when a pending write is abandoned.

Function
REQ-018 Command byte format: bit7=1 is a write, bit7=0 is a read; bits[6:0] are the address.
REQ-019 The state machine has the states IDLE, WAIT_DATA, WRITE, READ_REQ, READ_CAP, TX_WAIT and TX_SEND.
REQ-020 IDLE, on uart_rx_valid: latch bits[6:0] into reg_addr, then go to WAIT_DATA on a write or READ_REQ on a read.
REQ-021 WAIT_DATA, on uart_rx_valid: latch the byte into reg_wdata and go to WRITE.
REQ-022 WRITE: assert reg_we for exactly one cycle, then go to IDLE.
REQ-023 Write latency: reg_we is high on the cycle after the data-byte strobe.
REQ-024 READ_REQ: assert reg_re for one cycle, then go to READ_CAP.
REQ-025 READ_CAP: capture reg_rdata into uart_tx_data, then go to TX_WAIT.
REQ-026 TX_WAIT: wait while uart_tx_busy=1; when uart_tx_busy=0, go to TX_SEND.
REQ-027 TX_SEND: assert uart_tx_en for one cycle, then go to IDLE.
REQ-028 Read latency with uart_tx_busy=0: uart_tx_en is high 4 cycles after the command-byte strobe.
REQ-029 Timeout counter: 17 bits; cleared on entry to WAIT_DATA; increments each cycle in WAIT_DATA.
REQ-030 Timeout counter: at TIMEOUT_CYCLES-1 with no byte, pulse cmd_timeout, go to IDLE and issue no write.
REQ-031 If a byte arrives on the same cycle the timeout is reached, the byte wins: go to WRITE, no cmd_timeout.
REQ-032 A uart_rx_valid in WRITE, READ_REQ, READ_CAP, TX_WAIT or TX_SEND is discarded with a cmd_drop pulse; state is unaffected.
REQ-033 Only IDLE and WAIT_DATA consume bytes; uart_rx_valid is never queued.
REQ-034 uart_tx_data, reg_addr and reg_wdata hold their values until next overwritten.
REQ-035 reg_we, reg_re, uart_tx_en, cmd_drop and cmd_timeout are registered single-cycle pulses and are never high on consecutive cycles.

Reset
REQ-036 When resetn=0 at a clock edge: state becomes IDLE, the timeout counter becomes 0, and every output becomes 0.
REQ-037 A reset mid-command (any state) aborts it: no reg_we, reg_re or uart_tx_en is issued afterwards for that command.
REQ-038 The first byte after reset is treated as a command byte.

Structure
REQ-039 A shared package uart_pkg holds the state enumeration, the command-bit position (7), the address width (7) and the data width (8).
REQ-040 uart_pkg holds the TIMEOUT_CYCLES derivation (20*CLK_HZ/BIT_RATE, rounded up).
REQ-041 The timeout counter is one sub-module, uart_timeout_cnt, with inputs clr and en and a done output.
REQ-042 No other sub-modules are used.

Verification
REQ-043 Write: strobe 8'hAA then 8'h1F -> one reg_we pulse with reg_addr=7'h2A and reg_wdata=8'h1F, one cycle after the second strobe.
REQ-044 Read: strobe 8'h05, reg_rdata=8'h3C, uart_tx_busy=0 -> reg_re with reg_addr=7'h05, then uart_tx_en with uart_tx_data=8'h3C 4 cycles after the strobe.
REQ-045 Busy transmitter: read 8'h10 with uart_tx_busy=1 for 100 cycles -> uart_tx_en asserted exactly once, 1 cycle after busy falls.
REQ-046 Timeout: strobe 8'h81 and nothing else -> cmd_timeout at cycle TIMEOUT_CYCLES after the strobe, no reg_we; then strobe 8'h22 -> read of address 0x22.
REQ-047 Drop: strobe 8'h07 during TX_WAIT -> cmd_drop pulse; the read completes normally; the next command is processed.
REQ-048 Reset mid-write: strobe 8'h90, then resetn=0 for 2 cycles, then strobe 8'h55 -> no reg_we; 8'h55 is taken as a read of 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register-access controller.
// Also derives the write timeout (20 bit periods, rounded up) from clock and bit rate.
package uart_pkg;

    localparam int CMD_BIT = 32'sd7;
    localparam int ADDR_W  = 32'sd7;
    localparam int DATA_W  = 32'sd8;
    localparam int CNT_W   = 32'sd17;

    localparam int DEF_CLK_HZ   = 32'sd50000000;
    localparam int DEF_BIT_RATE = 32'sd11520;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        WRITE     = 3'd2,
        READ_REQ  = 3'd3,
        READ_CAP  = 3'd4,
        TX_WAIT   = 3'd5,
        TX_SEND   = 3'd6
    } state_e;

    // 64-bit arithmetic keeps 20*CLK_HZ from overflowing for fast clocks.
    function automatic int timeout_cycles(input longint clk_hz, input longint bit_rate);
        return int'((64'sd20 * clk_hz + bit_rate - 64'sd1) / bit_rate);
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Idle-gap counter for the data byte of a write command.
// done fires on the cycle whose increment brings the count to TIMEOUT_CYCLES-1.
module uart_timeout_cnt
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32'sd86806
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 32'sd2);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter: cleared on entry to the wait, advances while waiting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + 17'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered pulses downstream add a cycle, so decide one count early.
    assign done = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_reg_ctrl.sv
// Byte-command bridge from a UART to a register bus: write = cmd + data byte,
// read = cmd byte answered with one transmitted byte.
module uart_reg_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int BIT_RATE       = DEF_BIT_RATE,
    parameter int TIMEOUT_CYCLES = timeout_cycles(CLK_HZ, BIT_RATE)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              uart_rx_valid,
    input  logic [DATA_W-1:0] uart_rx_data,
    input  logic              uart_tx_busy,
    output logic              uart_tx_en,
    output logic [DATA_W-1:0] uart_tx_data,
    output logic              reg_we,
    output logic              reg_re,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              cmd_drop,
    output logic              cmd_timeout
);

    state_e state_r;
    state_e state_s;
    logic   addr_ld_s;
    logic   wdata_ld_s;
    logic   cnt_clr_s;
    logic   cnt_en_s;
    logic   cnt_done_s;
    logic   drop_s;
    logic   timeout_s;

    assign cnt_en_s = (state_r == WAIT_DATA);

    uart_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk   (clk),
        .resetn(resetn),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .done  (cnt_done_s)
    );

    // Next-state and load-enable decode.
    always_comb begin
        state_s    = state_r;
        addr_ld_s  = 1'b0;
        wdata_ld_s = 1'b0;
        cnt_clr_s  = 1'b0;
        drop_s     = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (uart_rx_valid) begin
                    addr_ld_s = 1'b1;
                    if (uart_rx_data[CMD_BIT]) begin
                        state_s   = WAIT_DATA;
                        cnt_clr_s = 1'b1;
                    end else begin
                        state_s = READ_REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_DATA: begin
                // A data byte coinciding with the timeout still completes the write.
                if (uart_rx_valid) begin
                    wdata_ld_s = 1'b1;
                    state_s    = WRITE;
                end else if (cnt_done_s) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = WAIT_DATA;
                end
            end
            WRITE: begin
                drop_s  = uart_rx_valid;
                state_s = IDLE;
            end
            READ_REQ: begin
                drop_s  = uart_rx_valid;
                state_s = READ_CAP;
            end
            READ_CAP: begin
                drop_s  = uart_rx_valid;
                state_s = TX_WAIT;
            end
            TX_WAIT: begin
                drop_s = uart_rx_valid;
                if (uart_tx_busy) begin
                    state_s = TX_WAIT;
                end else begin
                    state_s = TX_SEND;
                end
            end
            TX_SEND: begin
                drop_s  = uart_rx_valid;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered outputs; strobes follow the state being entered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= IDLE;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            uart_tx_en   <= 1'b0;
            cmd_drop     <= 1'b0;
            cmd_timeout  <= 1'b0;
            reg_addr     <= {ADDR_W{1'b0}};
            reg_wdata    <= {DATA_W{1'b0}};
            uart_tx_data <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            reg_we      <= (state_s == WRITE);
            reg_re      <= (state_s == READ_REQ);
            uart_tx_en  <= (state_s == TX_SEND);
            cmd_drop    <= drop_s;
            cmd_timeout <= timeout_s;
            if (addr_ld_s) begin
                reg_addr <= uart_rx_data[ADDR_W-1:0];
            end else begin
                reg_addr <= reg_addr;
            end
            if (wdata_ld_s) begin
                reg_wdata <= uart_rx_data;
            end else begin
                reg_wdata <= reg_wdata;
            end
            // Read data is valid the cycle after reg_re, i.e. while in READ_CAP.
            if (state_r == READ_CAP) begin
                uart_tx_data <= reg_rdata;
            end else begin
                uart_tx_data <= uart_tx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed self-checking bench for uart_reg_ctrl (timeout shortened to 40 cycles).
`timescale 1ns/1ps
module tb_uart_reg_ctrl;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_tx_busy;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       reg_we;
    logic       reg_re;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       cmd_drop;
    logic       cmd_timeout;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int tx_cnt   = 0;
    int to_cnt   = 0;
    int we_snap;
    int tx_snap;
    int to_snap;

    uart_reg_ctrl #(
        .CLK_HZ        (50000000),
        .BIT_RATE      (11520),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .cmd_drop     (cmd_drop),
        .cmd_timeout  (cmd_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_we)      we_cnt <= we_cnt + 1;
        if (uart_tx_en)  tx_cnt <= tx_cnt + 1;
        if (cmd_timeout) to_cnt <= to_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        step();
        uart_rx_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},      32'(reg_we),       32'd0);
        chk({tag, "_re"},      32'(reg_re),       32'd0);
        chk({tag, "_tx_en"},   32'(uart_tx_en),   32'd0);
        chk({tag, "_tx_data"}, 32'(uart_tx_data), 32'd0);
        chk({tag, "_addr"},    32'(reg_addr),     32'd0);
        chk({tag, "_wdata"},   32'(reg_wdata),    32'd0);
        chk({tag, "_drop"},    32'(cmd_drop),     32'd0);
        chk({tag, "_timeout"}, 32'(cmd_timeout),  32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        uart_tx_busy  = 1'b0;
        reg_rdata     = 8'h00;

        chk("default_timeout", 32'(uart_pkg::timeout_cycles(64'sd50000000, 64'sd11520)), 32'd86806);

        step();
        step();
        chk_idle_outputs("reset");
        resetn = 1'b1;
        step();

        // Write: 0xAA (write to 0x2A) then data 0x1F.
        strobe(8'hAA);
        chk("wr_no_early_we", 32'(reg_we), 32'd0);
        strobe(8'h1F);
        chk("wr_we", 32'(reg_we), 32'd1);
        chk("wr_addr", 32'(reg_addr), 32'h2A);
        chk("wr_wdata", 32'(reg_wdata), 32'h1F);
        step();
        chk("wr_we_single", 32'(reg_we), 32'd0);
        chk("wr_we_count", 32'(we_cnt), 32'd1);

        // Read of 0x05; rdata only valid during the READ_CAP cycle.
        tx_snap = tx_cnt;
        strobe(8'h05);
        chk("rd_re", 32'(reg_re), 32'd1);
        chk("rd_addr", 32'(reg_addr), 32'h05);
        reg_rdata = 8'h3C;
        step();
        chk("rd_re_single", 32'(reg_re), 32'd0);
        step();
        reg_rdata = 8'hFF;
        chk("rd_tx_en_early", 32'(uart_tx_en), 32'd0);
        chk("rd_tx_data_cap", 32'(uart_tx_data), 32'h3C);
        step();
        chk("rd_tx_en_lat4", 32'(uart_tx_en), 32'd1);
        chk("rd_tx_data", 32'(uart_tx_data), 32'h3C);
        step();
        chk("rd_tx_en_single", 32'(uart_tx_en), 32'd0);
        chk("rd_tx_count", 32'(tx_cnt - tx_snap), 32'd1);

        // Busy transmitter held for 100 cycles.
        uart_tx_busy = 1'b1;
        reg_rdata    = 8'h99;
        tx_snap      = tx_cnt;
        strobe(8'h10);
        for (int i = 0; i < 100; i++) step();
        chk("busy_no_tx", 32'(tx_cnt - tx_snap), 32'd0);
        uart_tx_busy = 1'b0;
        step();
        chk("busy_tx_en", 32'(uart_tx_en), 32'd1);
        chk("busy_tx_data", 32'(uart_tx_data), 32'h99);
        step();
        step();
        chk("busy_tx_once", 32'(tx_cnt - tx_snap), 32'd1);

        // Timeout: write command with no data byte.
        we_snap = we_cnt;
        to_snap = to_cnt;
        strobe(8'h81);
        for (int i = 0; i < TO - 2; i++) step();
        chk("to_not_early", 32'(cmd_timeout), 32'd0);
        step();
        chk("to_pulse", 32'(cmd_timeout), 32'd1);
        step();
        chk("to_single", 32'(cmd_timeout), 32'd0);
        chk("to_no_write", 32'(we_cnt - we_snap), 32'd0);
        strobe(8'h22);
        chk("to_next_re", 32'(reg_re), 32'd1);
        chk("to_next_addr", 32'(reg_addr), 32'h22);
        step();
        step();
        step();
        step();

        // Data byte lands on the very cycle the timeout would fire.
        to_snap = to_cnt;
        strobe(8'hC3);
        for (int i = 0; i < TO - 2; i++) step();
        strobe(8'h5A);
        chk("edge_we", 32'(reg_we), 32'd1);
        chk("edge_no_to", 32'(cmd_timeout), 32'd0);
        chk("edge_addr", 32'(reg_addr), 32'h43);
        chk("edge_wdata", 32'(reg_wdata), 32'h5A);
        step();
        step();
        chk("edge_to_count", 32'(to_cnt - to_snap), 32'd0);

        // Byte dropped while waiting on the transmitter.
        uart_tx_busy = 1'b1;
        reg_rdata    = 8'h77;
        strobe(8'h12);
        step();
        step();
        strobe(8'h07);
        chk("drop_pulse", 32'(cmd_drop), 32'd1);
        chk("drop_addr_kept", 32'(reg_addr), 32'h12);
        uart_tx_busy = 1'b0;
        step();
        chk("drop_single", 32'(cmd_drop), 32'd0);
        chk("drop_tx_en", 32'(uart_tx_en), 32'd1);
        chk("drop_tx_data", 32'(uart_tx_data), 32'h77);
        step();
        strobe(8'hB0);
        strobe(8'hE1);
        chk("drop_next_we", 32'(reg_we), 32'd1);
        chk("drop_next_addr", 32'(reg_addr), 32'h30);
        chk("drop_next_wdata", 32'(reg_wdata), 32'hE1);
        step();

        // Reset in the middle of a write.
        we_snap = we_cnt;
        strobe(8'h90);
        resetn = 1'b0;
        step();
        step();
        chk_idle_outputs("midrst");
        resetn = 1'b1;
        strobe(8'h55);
        chk("midrst_re", 32'(reg_re), 32'd1);
        chk("midrst_addr", 32'(reg_addr), 32'h55);
        chk("midrst_we_now", 32'(reg_we), 32'd0);
        step();
        step();
        step();
        step();
        chk("midrst_no_write", 32'(we_cnt - we_snap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
